// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack memory
// handshake and holds each instruction for the control unit until released.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic             instr_valid,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_e;

    state_e             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        instr_q;
    logic               instr_valid_q;
    logic [31:0]        pc_out_q;
    logic [CNT_W-1:0]   fetch_count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            pc_out_q      <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state_q       <= VALID;
                        instr_q       <= imem_rdata;
                        pc_out_q      <= pc_q;
                        instr_valid_q <= 1'b1;
                        if (fetch_count_q != {CNT_W{1'b1}})
                            fetch_count_q <= fetch_count_q + CNT_W'(1);
                    end
                end
                VALID: begin
                    // Redirect outranks stall; the sequential address is never issued.
                    if (branch_taken) begin
                        pc_q          <= {branch_target[31:2], 2'b00};
                        instr_valid_q <= 1'b0;
                        state_q       <= FETCH;
                    end else if (!stall) begin
                        pc_q          <= pc_q + 32'd4;
                        instr_valid_q <= 1'b0;
                        state_q       <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Decoded from registered state only, so reset drops the request at once.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + 32'd4;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one instance from address 0 for sequential
// fetch/wait/stall/branch, one at the top of memory for wrap, saturation, reset.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: RESET_PC = 0, default counter width
    logic        rst_n_a;
    logic        req_a, ack_a, valid_a;
    logic [31:0] addr_a, rdata_a, instr_a, pc_out_a, pc4_a, target_a;
    logic        stall_a, br_a;
    logic [5:0]  op_a;
    logic [15:0] cnt_a;

    // Instance B: RESET_PC at top of memory, 2-bit counter to reach saturation
    logic        rst_n_b;
    logic        req_b, valid_b;
    logic [31:0] addr_b, instr_b, pc_out_b, pc4_b;
    logic [5:0]  op_b;
    logic [1:0]  cnt_b;

    instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n_a),
        .imem_req(req_a), .imem_addr(addr_a), .imem_ack(ack_a), .imem_rdata(rdata_a),
        .stall(stall_a), .branch_taken(br_a), .branch_target(target_a),
        .instr(instr_a), .opcode(op_a), .instr_valid(valid_a),
        .pc_out(pc_out_a), .pc_plus4(pc4_a), .fetch_count(cnt_a)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .imem_req(req_b), .imem_addr(addr_b), .imem_ack(1'b1), .imem_rdata(32'h2400_0001),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0000_0000),
        .instr(instr_b), .opcode(op_b), .instr_valid(valid_b),
        .pc_out(pc_out_b), .pc_plus4(pc4_b), .fetch_count(cnt_b)
    );

    // Instruction memory contents seen by instance A
    always_comb begin
        case (addr_a)
            32'h0000_0000: rdata_a = 32'h0000_0000;
            32'h0000_0004: rdata_a = 32'h8C00_0000;
            32'h0000_0008: rdata_a = 32'hAC00_0000;
            32'h0000_000C: rdata_a = 32'h1000_0000;
            32'h0000_0010: rdata_a = 32'h1000_0005;
            32'h0000_0100: rdata_a = 32'h8C22_0008;
            default:       rdata_a = 32'hFFFF_FFFF;
        endcase
    end

    logic saw_14 = 1'b0;
    always @(posedge clk) if (req_a && addr_a == 32'h0000_0014) saw_14 = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        ack_a = 1'b1; stall_a = 1'b0; br_a = 1'b0; target_a = 32'h0;

        @(negedge clk);
        check("rst_req",    {31'b0, req_a},   32'h0);
        check("rst_instr",  instr_a,          32'h0);
        check("rst_opcode", {26'b0, op_a},    32'h0);
        check("rst_valid",  {31'b0, valid_a}, 32'h0);
        check("rst_pc_out", pc_out_a,         32'h0);
        check("rst_pc4",    pc4_a,            32'h4);
        check("rst_count",  {16'b0, cnt_a},   32'h0);

        // Sequential fetch, zero-wait memory
        rst_n_a = 1'b1;
        cycle();
        check("f0_req",  {31'b0, req_a},   32'h1);
        check("f0_addr", addr_a,           32'h0);
        check("f0_valid",{31'b0, valid_a}, 32'h0);
        cycle();
        check("v0_valid",{31'b0, valid_a}, 32'h1);
        check("v0_op",   {26'b0, op_a},    32'h00);
        check("v0_req",  {31'b0, req_a},   32'h0);
        cycle();
        check("f1_addr", addr_a,           32'h4);
        check("f1_valid",{31'b0, valid_a}, 32'h0);
        cycle();
        check("v1_op",   {26'b0, op_a},    32'h23);
        check("v1_pc4",  pc4_a,            32'h8);
        check("v1_count",{16'b0, cnt_a},   32'h2);

        // Memory wait: ack low for three FETCH cycles at address 8
        ack_a = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            check("wait_req",   {31'b0, req_a},   32'h1);
            check("wait_addr",  addr_a,           32'h8);
            check("wait_valid", {31'b0, valid_a}, 32'h0);
            cycle();
        end
        check("wait_addr4", addr_a, 32'h8);
        ack_a = 1'b1;
        cycle();
        check("v2_valid", {31'b0, valid_a}, 32'h1);
        check("v2_instr", instr_a,          32'hAC00_0000);
        check("v2_op",    {26'b0, op_a},    32'h2B);
        check("v2_count", {16'b0, cnt_a},   32'h3);

        // Stall for five cycles while holding the SW
        stall_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_instr", instr_a,          32'hAC00_0000);
            check("stall_pc",    pc_out_a,         32'h8);
            check("stall_valid", {31'b0, valid_a}, 32'h1);
            check("stall_req",   {31'b0, req_a},   32'h0);
        end
        stall_a = 1'b0;
        cycle();
        check("post_stall_addr", addr_a, 32'hC);
        cycle();
        check("v3_op",    {26'b0, op_a},  32'h04);
        check("v3_count", {16'b0, cnt_a}, 32'h4);

        // Branch redirect from pc=0x10 with stall also asserted
        cycle();
        check("f4_addr", addr_a, 32'h10);
        cycle();
        check("v4_pc", pc_out_a, 32'h10);
        br_a = 1'b1; stall_a = 1'b1; target_a = 32'h0000_0103;
        cycle();
        check("br_addr", addr_a,         32'h100);
        check("br_req",  {31'b0, req_a}, 32'h1);
        br_a = 1'b0; stall_a = 1'b0;
        cycle();
        check("br_instr", instr_a,  32'h8C22_0008);
        check("br_pc",    pc_out_a, 32'h100);
        check("br_pc4",   pc4_a,    32'h104);
        check("no_0x14",  {31'b0, saw_14}, 32'h0);

        // Wrap at top of memory, counter saturation, asynchronous reset
        rst_n_b = 1'b1;
        cycle();
        check("wr_addr0", addr_b, 32'hFFFF_FFFC);
        cycle();
        check("wr_pc",   pc_out_b,         32'hFFFF_FFFC);
        check("wr_pc4",  pc4_b,            32'h0);
        check("wr_cnt1", {30'b0, cnt_b},   32'h1);
        cycle();
        check("wr_addr1", addr_b, 32'h0);
        for (int i = 0; i < 5; i++) cycle();
        check("sat_cnt",   {30'b0, cnt_b},   32'h3);
        check("sat_valid", {31'b0, valid_b}, 32'h1);
        cycle();
        check("pre_rst_req", {31'b0, req_b}, 32'h1);
        #1 rst_n_b = 1'b0;
        #1;
        check("arst_req",   {31'b0, req_b},   32'h0);
        check("arst_valid", {31'b0, valid_b}, 32'h0);
        check("arst_cnt",   {30'b0, cnt_b},   32'h0);
        check("arst_instr", instr_b,          32'h0);
        @(negedge clk);
        rst_n_b = 1'b1;
        cycle();
        check("restart_addr", addr_b,         32'hFFFF_FFFC);
        check("restart_req",  {31'b0, req_b}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
